// File: rtl/seq_pair_detect_cnt.sv
// Two-pattern serial sequence detector with saturating per-pattern run counters,
// optional gap timeout and a registered threshold alarm.
module seq_pair_detect_cnt #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_A   = 3'b101,
    parameter logic [PAT_W-1:0] PAT_B   = 3'b100,
    parameter int               THRESH  = 2,
    parameter int               CNT_W   = 4,
    parameter bit               OVERLAP = 1'b1,
    parameter int               MAX_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    output logic             hit_a,
    output logic             hit_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             z
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int GAP_W  = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((MAX_GAP > 0) ? MAX_GAP - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  THR       = CNT_W'(THRESH);

    logic [PAT_W-1:0]  win_q, win_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic              hit_a_q, hit_a_d;
    logic              hit_b_q, hit_b_d;
    logic              z_q, z_d;

    logic [PAT_W-1:0] next_win;
    logic             armed;
    logic             m_a;
    logic             m_b;

    // A match needs PAT_W bits accepted since reset (or since the last match when non-overlapping).
    assign next_win = {win_q[PAT_W-2:0], x};
    assign armed    = (fill_q >= FILL_ARM);
    assign m_a      = armed && (next_win == PAT_A);
    assign m_b      = armed && (next_win == PAT_B);

    always_comb begin
        win_d   = win_q;
        fill_d  = fill_q;
        gap_d   = gap_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        hit_a_d = 1'b0;
        hit_b_d = 1'b0;
        // NOTE: z is evaluated outside the enable so it keeps tracking the held counters.
        z_d     = (cnt_a_q >= THR) || (cnt_b_q >= THR);

        if (en) begin
            win_d   = next_win;
            hit_a_d = m_a;
            hit_b_d = m_b;
            if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;

            if (m_a || m_b) begin
                gap_d = '0;
                if (!OVERLAP) fill_d = '0;
                if (m_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + 1'b1;
                if (m_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 1'b1;
                if (m_a && !m_b) cnt_b_d = '0;
                if (m_b && !m_a) cnt_a_d = '0;
            end else if (MAX_GAP > 0) begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '0;
            fill_q  <= '0;
            gap_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            hit_a_q <= 1'b0;
            hit_b_q <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            gap_q   <= gap_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            hit_a_q <= hit_a_d;
            hit_b_q <= hit_b_d;
            z_q     <= z_d;
        end
    end

    assign hit_a = hit_a_q;
    assign hit_b = hit_b_q;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
    assign z     = z_q;

endmodule

// File: tb/tb_seq_pair_detect_cnt.sv
// Scoreboard bench for seq_pair_detect_cnt: four parameterisations, directed vectors,
// expected outputs queued by the driver and checked by an independent monitor.
module tb_seq_pair_detect_cnt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: 0 defaults, 1 non-overlapping, 2 gap timeout, 3 narrow counters.
    logic rst_v [4];
    logic en_v  [4];
    logic x_v   [4];

    logic       ha0, hb0, z0, ha1, hb1, z1, ha2, hb2, z2, ha3, hb3, z3;
    logic [3:0] ca0, cb0, ca1, cb1, ca2, cb2;
    logic [1:0] ca3, cb3;

    seq_pair_detect_cnt u_def (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .x(x_v[0]),
        .hit_a(ha0), .hit_b(hb0), .cnt_a(ca0), .cnt_b(cb0), .z(z0)
    );

    seq_pair_detect_cnt #(.OVERLAP(1'b0)) u_novl (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .x(x_v[1]),
        .hit_a(ha1), .hit_b(hb1), .cnt_a(ca1), .cnt_b(cb1), .z(z1)
    );

    // PAT_B=111 keeps the run of zeros in the gap test free of B matches.
    seq_pair_detect_cnt #(.PAT_B(3'b111), .MAX_GAP(3)) u_gap (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .x(x_v[2]),
        .hit_a(ha2), .hit_b(hb2), .cnt_a(ca2), .cnt_b(cb2), .z(z2)
    );

    seq_pair_detect_cnt #(.CNT_W(2), .THRESH(2)) u_sat (
        .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .x(x_v[3]),
        .hit_a(ha3), .hit_b(hb3), .cnt_a(ca3), .cnt_b(cb3), .z(z3)
    );

    // Observed vector {hit_a, hit_b, cnt_a[3:0], cnt_b[3:0], z}
    logic [10:0] obs [4];
    assign obs[0] = {ha0, hb0, ca0, cb0, z0};
    assign obs[1] = {ha1, hb1, ca1, cb1, z1};
    assign obs[2] = {ha2, hb2, ca2, cb2, z2};
    assign obs[3] = {ha3, hb3, 2'b00, ca3, 2'b00, cb3, z3};

    typedef struct {
        int          dut;
        int          due;
        logic [10:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb [$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] ev(input bit ha, input bit hb, input int ca, input int cb, input bit zz);
        return {ha, hb, 4'(ca), 4'(cb), zz};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got ha=%b hb=%b ca=%0d cb=%0d z=%b, want ha=%b hb=%b ca=%0d cb=%0d z=%b",
                     name, act[10], act[9], act[8:5], act[4:1], act[0],
                     exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // Monitor: every output is presented after its edge; compare once that edge has passed.
    sb_item_t it;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            check(it.name, obs[it.dut], it.exp);
        end
    end

    task automatic step(input int d, input bit r, input bit e, input bit xv,
                        input logic [10:0] exp, input string name);
        sb_item_t item;
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b0;
            en_v[i]  = 1'b0;
            x_v[i]   = 1'b0;
        end
        rst_v[d] = r;
        en_v[d]  = e;
        x_v[d]   = xv;
        item.dut  = d;
        item.due  = cyc + 1;
        item.exp  = exp;
        item.name = name;
        sb.push_back(item);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b1;
            en_v[i]  = 1'b0;
            x_v[i]   = 1'b0;
        end
        @(posedge clk);
        #1;

        // Repeated A with overlap: hits at bits 3 and 5, z one cycle after cnt_a=2.
        step(0, 1, 0, 0, ev(0,0,0,0,0), "t1_reset");
        step(0, 0, 1, 1, ev(0,0,0,0,0), "t1_b1");
        step(0, 0, 1, 0, ev(0,0,0,0,0), "t1_b2");
        step(0, 0, 1, 1, ev(1,0,1,0,0), "t1_b3_hit");
        step(0, 0, 1, 0, ev(0,0,1,0,0), "t1_b4");
        step(0, 0, 1, 1, ev(1,0,2,0,0), "t1_b5_hit");
        step(0, 0, 0, 0, ev(0,0,2,0,1), "t1_z_rise");
        step(0, 0, 0, 0, ev(0,0,2,0,1), "t1_z_hold");

        // A then B: B match clears cnt_a, z never rises.
        step(0, 1, 0, 0, ev(0,0,0,0,0), "t2_reset");
        step(0, 0, 1, 1, ev(0,0,0,0,0), "t2_b1");
        step(0, 0, 1, 0, ev(0,0,0,0,0), "t2_b2");
        step(0, 0, 1, 1, ev(1,0,1,0,0), "t2_b3_hit_a");
        step(0, 0, 1, 1, ev(0,0,1,0,0), "t2_b4");
        step(0, 0, 1, 0, ev(0,0,1,0,0), "t2_b5");
        step(0, 0, 1, 0, ev(0,1,0,1,0), "t2_b6_hit_b");
        step(0, 0, 0, 0, ev(0,0,0,1,0), "t2_after");

        // Enable hold, then reset discards partial window 101.
        step(0, 1, 0, 0, ev(0,0,0,0,0), "t4_reset");
        step(0, 0, 1, 1, ev(0,0,0,0,0), "t4_b1");
        step(0, 0, 1, 0, ev(0,0,0,0,0), "t4_b2");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, ev(0,0,0,0,0), "t4_en_low");
        step(0, 0, 1, 1, ev(1,0,1,0,0), "t4_b3_hit");
        step(0, 0, 0, 1, ev(0,0,1,0,0), "t4_hold");
        step(0, 1, 1, 1, ev(0,0,0,0,0), "t4_reset_mid");
        step(0, 0, 1, 0, ev(0,0,0,0,0), "t4_post_b1");
        step(0, 0, 1, 1, ev(0,0,0,0,0), "t4_post_b2_nohit");

        // Non-overlapping: hit at bits 3 and 7 only.
        step(1, 1, 0, 0, ev(0,0,0,0,0), "t3_reset");
        step(1, 0, 1, 1, ev(0,0,0,0,0), "t3_b1");
        step(1, 0, 1, 0, ev(0,0,0,0,0), "t3_b2");
        step(1, 0, 1, 1, ev(1,0,1,0,0), "t3_b3_hit");
        step(1, 0, 1, 0, ev(0,0,1,0,0), "t3_b4");
        step(1, 0, 1, 1, ev(0,0,1,0,0), "t3_b5_nohit");
        step(1, 0, 1, 0, ev(0,0,1,0,0), "t3_b6");
        step(1, 0, 1, 1, ev(1,0,2,0,0), "t3_b7_hit");
        step(1, 0, 0, 0, ev(0,0,2,0,1), "t3_z_rise");

        // Gap timeout of 3 non-matching bits clears cnt_a.
        step(2, 1, 0, 0, ev(0,0,0,0,0), "t5_reset");
        step(2, 0, 1, 1, ev(0,0,0,0,0), "t5_b1");
        step(2, 0, 1, 0, ev(0,0,0,0,0), "t5_b2");
        step(2, 0, 1, 1, ev(1,0,1,0,0), "t5_b3_hit");
        step(2, 0, 1, 0, ev(0,0,1,0,0), "t5_gap1");
        step(2, 0, 1, 0, ev(0,0,1,0,0), "t5_gap2");
        step(2, 0, 1, 0, ev(0,0,0,0,0), "t5_gap3_clear");
        step(2, 0, 1, 1, ev(0,0,0,0,0), "t5_b7");
        step(2, 0, 1, 0, ev(0,0,0,0,0), "t5_b8");
        step(2, 0, 1, 1, ev(1,0,1,0,0), "t5_b9_hit");
        step(2, 0, 0, 0, ev(0,0,1,0,0), "t5_z_low");

        // 2-bit counters saturate at 3.
        step(3, 1, 0, 0, ev(0,0,0,0,0), "t6_reset");
        for (int i = 1; i <= 10; i++) begin
            automatic bit hit = (i >= 3) && (i % 2 == 1);
            automatic int ca  = (i < 3) ? 0 : ((i - 1) / 2 > 3 ? 3 : (i - 1) / 2);
            automatic bit zz  = (i >= 6);
            step(3, 0, 1, i[0], ev(hit, 0, ca, 0, zz), $sformatf("t6_b%0d", i));
        end
        step(3, 0, 0, 0, ev(0,0,3,0,1), "t6_after");

        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b0;
            en_v[i]  = 1'b0;
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
